// File: rtl/fetch_stage.sv
// DLX instruction fetch with IF/ID register: PC update, memory wait tracking, redirects from ID and EX.
// One cycle fetch-to-IF/ID; stall holds PC and IF/ID, but an EX redirect overrides stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] i_address,
  output logic        i_read_enable,
  input  logic [31:0] i_data_read,
  input  logic        i_mem_ready,
  input  logic        stall,
  input  logic        redirect_id,
  input  logic [31:0] target_id,
  input  logic        redirect_ex,
  input  logic [31:0] target_ex,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] instr_d, pc4_d;
  logic        valid_d, timeout_d;
  logic [31:0] pc_plus4;

  assign i_address = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      wait_cnt_q    <= 16'h0;
      id_instr      <= 32'h0;
      id_pc_plus4   <= 32'h0;
      id_valid      <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      id_instr      <= instr_d;
      id_pc_plus4   <= pc4_d;
      id_valid      <= valid_d;
      fetch_timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    instr_d       = id_instr;
    pc4_d         = id_pc_plus4;
    valid_d       = id_valid;
    timeout_d     = fetch_timeout;
    i_read_enable = (state_q != ST_BOOT);

    if (state_q == ST_BOOT) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (redirect_ex) begin
      // EX holds the older instruction, so its redirect wins even over a stall
      pc_d       = {target_ex[31:2], 2'b00};
      instr_d    = 32'h0;
      pc4_d      = 32'h0;
      valid_d    = 1'b0;
      state_d    = ST_RUN;
      wait_cnt_d = 16'h0;
    end else if (stall) begin
      state_d = state_q;
    end else if (redirect_id) begin
      pc_d       = {target_id[31:2], 2'b00};
      instr_d    = 32'h0;
      pc4_d      = 32'h0;
      valid_d    = 1'b0;
      state_d    = ST_RUN;
      wait_cnt_d = 16'h0;
    end else if (i_mem_ready) begin
      instr_d    = i_data_read;
      pc4_d      = pc_plus4;
      valid_d    = 1'b1;
      pc_d       = pc_plus4;
      state_d    = ST_RUN;
      wait_cnt_d = 16'h0;
    end else begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
        if ({16'h0, wait_cnt_d} >= WAIT_LIMIT) begin
          timeout_d = 1'b1;
        end
      end else begin
        state_d = ST_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, two instances with different reset PCs.
module tb_fetch_stage;

  localparam int unsigned LIMIT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rdy, st, rid, rex;
  logic [31:0] tid, tex;

  logic [31:0] addr0, data0, instr0, pc40;
  logic        re0, valid0, tmo0;
  logic [31:0] addr1, data1, instr1, pc41;
  logic        re1, valid1, tmo1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        timeout;
    logic        boot;
    logic        mem_waiting;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t m0, m1;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign data0 = mem(addr0);
  assign data1 = mem(addr1);

  fetch_stage #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(LIMIT)) u0 (
    .clk(clk), .reset_n(reset_n), .i_address(addr0), .i_read_enable(re0),
    .i_data_read(data0), .i_mem_ready(rdy), .stall(st),
    .redirect_id(rid), .target_id(tid), .redirect_ex(rex), .target_ex(tex),
    .id_instr(instr0), .id_pc_plus4(pc40), .id_valid(valid0), .fetch_timeout(tmo0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .WAIT_LIMIT(LIMIT)) u1 (
    .clk(clk), .reset_n(reset_n), .i_address(addr1), .i_read_enable(re1),
    .i_data_read(data1), .i_mem_ready(rdy), .stall(st),
    .redirect_id(rid), .target_id(tid), .redirect_ex(rex), .target_ex(tex),
    .id_instr(instr1), .id_pc_plus4(pc41), .id_valid(valid1), .fetch_timeout(tmo1)
  );

  function automatic mdl_t mdl_reset(input logic [31:0] rpc);
    mdl_t m;
    m = '0;
    m.pc   = rpc;
    m.boot = 1'b1;
    return m;
  endfunction

  function automatic mdl_t bubble(input mdl_t m);
    mdl_t n = m;
    n.instr = 32'h0;
    n.pc4   = 32'h0;
    n.valid = 1'b0;
    return n;
  endfunction

  // Reference behaviour straight from the priority rules
  function automatic mdl_t step(input mdl_t m);
    mdl_t n = m;
    if (m.boot) begin
      n = bubble(m);
      n.boot = 1'b0;
    end else if (rex) begin
      n = bubble(m);
      n.pc = tex & 32'hFFFF_FFFC;
      n.mem_waiting = 1'b0;
      n.cnt = 16'h0;
    end else if (st) begin
      n = m;
    end else if (rid) begin
      n = bubble(m);
      n.pc = tid & 32'hFFFF_FFFC;
      n.mem_waiting = 1'b0;
      n.cnt = 16'h0;
    end else if (rdy) begin
      n.instr = mem(m.pc);
      n.pc4   = m.pc + 32'd4;
      n.valid = 1'b1;
      n.pc    = m.pc + 32'd4;
      n.mem_waiting = 1'b0;
      n.cnt = 16'h0;
    end else begin
      n = bubble(m);
      if (m.mem_waiting) begin
        if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
        if (int'(n.cnt) >= int'(LIMIT)) n.timeout = 1'b1;
      end
      n.mem_waiting = 1'b1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    check("u0.addr",    addr0,          m0.pc);
    check("u0.re",      {31'h0, re0},   {31'h0, ~m0.boot});
    check("u0.instr",   instr0,         m0.instr);
    check("u0.pc4",     pc40,           m0.pc4);
    check("u0.valid",   {31'h0, valid0}, {31'h0, m0.valid});
    check("u0.timeout", {31'h0, tmo0},  {31'h0, m0.timeout});
    check("u1.addr",    addr1,          m1.pc);
    check("u1.re",      {31'h0, re1},   {31'h0, ~m1.boot});
    check("u1.instr",   instr1,         m1.instr);
    check("u1.pc4",     pc41,           m1.pc4);
    check("u1.valid",   {31'h0, valid1}, {31'h0, m1.valid});
    check("u1.timeout", {31'h0, tmo1},  {31'h0, m1.timeout});
  endtask

  task automatic tick(input logic r, input logic s, input logic ri, input logic [31:0] ti,
                      input logic re, input logic [31:0] te);
    rdy = r; st = s; rid = ri; tid = ti; rex = re; tex = te;
    m0 = step(m0);
    m1 = step(m1);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  logic [31:0] a_hold, i_hold;

  initial begin
    rdy = 1'b1; st = 1'b0; rid = 1'b0; rex = 1'b0; tid = '0; tex = '0;
    reset_n = 1'b0;
    m0 = mdl_reset(32'h0000_0000);
    m1 = mdl_reset(32'hFFFF_FFFC);
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    reset_n = 1'b1;
    #1;
    check("boot.re", {31'h0, re0}, 32'h0);

    // T1: BOOT then first fetch
    tick(1, 0, 0, 0, 0, 0);
    check("t1.bubble", {31'h0, valid0}, 32'h0);
    tick(1, 0, 0, 0, 0, 0);
    check("t1.instr", instr0, 32'h2001_0005);
    check("t1.pc4",   pc40,   32'h4);
    check("t1.addr",  addr0,  32'h4);
    // T6 first half: PC wrap on the second instance
    check("t6.pc4",   pc41,   32'h0);
    check("t6.addr",  addr1,  32'h0);

    // T2: stall for three cycles
    tick(1, 0, 0, 0, 0, 0);
    a_hold = addr0;
    i_hold = instr0;
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0, 0, 0, 0);
      check("t2.addr_frozen",  addr0,  a_hold);
      check("t2.instr_frozen", instr0, i_hold);
    end
    tick(1, 0, 0, 0, 0, 0);
    check("t2.addr_adv", addr0,  a_hold + 32'd4);
    check("t2.instr",    instr0, mem(a_hold));

    // T3: ID redirect
    tick(1, 0, 1, 32'h40, 0, 0);
    check("t3.valid", {31'h0, valid0}, 32'h0);
    check("t3.addr",  addr0, 32'h40);
    tick(1, 0, 0, 0, 0, 0);
    check("t3.instr", instr0, mem(32'h40));
    check("t3.addr2", addr0, 32'h44);

    // T4: EX redirect beats stall, ID redirect is ignored under stall
    tick(1, 1, 1, 32'h80, 1, 32'h100);
    check("t4.addr",  addr0, 32'h100);
    check("t4.valid", {31'h0, valid0}, 32'h0);
    tick(1, 1, 1, 32'h80, 0, 0);
    check("t4.hold", addr0, 32'h100);

    // T6 second half: misaligned EX target
    tick(1, 0, 0, 0, 1, 32'h103);
    check("t6.align0", addr0, 32'h100);
    check("t6.align1", addr1, 32'h100);

    // T5: memory not ready for LIMIT+2 cycles
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= int'(LIMIT) + 2; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      check("t5.valid", {31'h0, valid0}, 32'h0);
      if (k == int'(LIMIT)) check("t5.not_yet", {31'h0, tmo0}, 32'h0);
      if (k == int'(LIMIT) + 1) check("t5.rise", {31'h0, tmo0}, 32'h1);
    end
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check("t5.sticky", {31'h0, tmo0}, 32'h1);

    // Asynchronous reset in the middle of a wait
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    m0 = mdl_reset(32'h0000_0000);
    m1 = mdl_reset(32'hFFFF_FFFC);
    check("arst.timeout", {31'h0, tmo0}, 32'h0);
    check("arst.addr",    addr0, 32'h0);
    cmp_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(1, 0, 0, 0, 0, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic r, s, ri, re;
      r  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) < 2);
      ri = ($urandom_range(0, 9) == 0);
      re = ($urandom_range(0, 14) == 0);
      tick(r, s, ri, $urandom, re, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
